// File: rtl/serial_mem_bridge.sv
// serial_mem_bridge: framed UART byte commands to a word-addressed memory port.
// Define SERIAL_BRIDGE_TIMEOUT_EN to abort partial frames after TIMEOUT idle cycles.
module serial_mem_bridge #(
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 16,
    parameter int TIMEOUT   = 1000000
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata,
    output logic              busy,
    output logic [7:0]        err_count
);
    localparam int NB = DATA_W / 8;
    localparam int AB = (ADDR_W + 7) / 8;
    localparam logic [7:0] OP_W  = 8'h57;
    localparam logic [7:0] OP_R  = 8'h52;
    localparam logic [7:0] B_ACK = 8'h4B;
    localparam logic [7:0] B_ERR = 8'h3F;

    typedef enum logic [3:0] {
        S_IDLE, S_LEN, S_ADDR, S_WDATA, S_WREQ,
        S_RREQ, S_RWAIT, S_RSEND, S_ACK, S_ERR
    } state_t;

    state_t            r_state, w_state_n;
    logic              r_rx_ready, w_rx_ready_n;
    logic              r_tx_valid, w_tx_valid_n;
    logic [7:0]        r_tx_data, w_tx_data_n;
    logic              r_req_valid, w_req_valid_n;
    logic              r_we, w_we_n;
    logic [ADDR_W-1:0] r_addr, w_addr_n;
    logic [DATA_W-1:0] r_wdata, w_wdata_n;
    logic [DATA_W-1:0] r_rdata, w_rdata_n;
    logic              r_busy, w_busy_n;
    logic [7:0]        r_err, w_err_n;
    logic [7:0]        r_bcnt, w_bcnt_n;
    logic [7:0]        r_wcnt, w_wcnt_n;

    logic              w_rx_fire, w_tx_fire, w_req_fire;
    logic              w_tmo_hit;
    logic [DATA_W-1:0] w_rsh;

    assign w_rx_fire  = r_rx_ready & rx_valid;
    assign w_tx_fire  = r_tx_valid & tx_ready;
    assign w_req_fire = r_req_valid & mem_req_ready;
    assign w_rsh      = r_rdata << 8;

`ifdef SERIAL_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_tmo;
    logic          w_tmo_run;

    assign w_tmo_run = (r_state == S_LEN) || (r_state == S_ADDR) ||
                       (r_state == S_WDATA);
    assign w_tmo_hit = w_tmo_run && (r_tmo == TW'(TIMEOUT - 1));

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst || w_rx_fire || !w_tmo_run)
            r_tmo <= '0;
        else if (!w_tmo_hit)
            r_tmo <= r_tmo + 1'b1;
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        w_state_n     = r_state;
        w_tx_valid_n  = r_tx_valid;
        w_tx_data_n   = r_tx_data;
        w_req_valid_n = r_req_valid;
        w_we_n        = r_we;
        w_addr_n      = r_addr;
        w_wdata_n     = r_wdata;
        w_rdata_n     = r_rdata;
        w_err_n       = r_err;
        w_bcnt_n      = r_bcnt;
        w_wcnt_n      = r_wcnt;
        unique case (r_state)
            S_IDLE: if (w_rx_fire) begin
                if (rx_data == OP_W || rx_data == OP_R) begin
                    w_state_n = S_LEN;
                    w_we_n    = (rx_data == OP_W);
                end else begin
                    w_state_n = S_ERR;
                end
            end
            S_LEN: if (w_rx_fire) begin
                w_wcnt_n = rx_data;
                w_bcnt_n = 8'd0;
                if (rx_data == 8'd0 || rx_data > 8'(BURST_MAX))
                    w_state_n = S_ERR;
                else
                    w_state_n = S_ADDR;
            end
            S_ADDR: if (w_rx_fire) begin
                w_addr_n = (r_addr << 8) | ADDR_W'(rx_data);
                if (r_bcnt == 8'(AB - 1)) begin
                    w_bcnt_n = 8'd0;
                    if (r_we) begin
                        w_state_n = S_WDATA;
                    end else begin
                        w_state_n     = S_RREQ;
                        w_req_valid_n = 1'b1;
                    end
                end else begin
                    w_bcnt_n = r_bcnt + 8'd1;
                end
            end
            S_WDATA: if (w_rx_fire) begin
                w_wdata_n = (r_wdata << 8) | DATA_W'(rx_data);
                if (r_bcnt == 8'(NB - 1)) begin
                    w_bcnt_n      = 8'd0;
                    w_state_n     = S_WREQ;
                    w_req_valid_n = 1'b1;
                end else begin
                    w_bcnt_n = r_bcnt + 8'd1;
                end
            end
            S_WREQ: if (w_req_fire) begin
                w_req_valid_n = 1'b0;
                w_addr_n      = r_addr + 1'b1;
                w_wcnt_n      = r_wcnt - 8'd1;
                if (r_wcnt == 8'd1) begin
                    w_state_n    = S_ACK;
                    w_tx_valid_n = 1'b1;
                    w_tx_data_n  = B_ACK;
                end else begin
                    w_state_n = S_WDATA;
                end
            end
            S_RREQ: if (w_req_fire) begin
                w_req_valid_n = 1'b0;
                w_addr_n      = r_addr + 1'b1;
                w_state_n     = S_RWAIT;
            end
            S_RWAIT: if (mem_rsp_valid) begin
                w_rdata_n    = mem_rsp_rdata;
                w_tx_valid_n = 1'b1;
                w_tx_data_n  = mem_rsp_rdata[DATA_W-1 -: 8];
                w_bcnt_n     = 8'd0;
                w_state_n    = S_RSEND;
            end
            S_RSEND: if (w_tx_fire) begin
                if (r_bcnt == 8'(NB - 1)) begin
                    w_bcnt_n     = 8'd0;
                    w_wcnt_n     = r_wcnt - 8'd1;
                    w_tx_valid_n = 1'b0;
                    if (r_wcnt == 8'd1) begin
                        w_state_n = S_IDLE;
                    end else begin
                        w_state_n     = S_RREQ;
                        w_req_valid_n = 1'b1;
                    end
                end else begin
                    w_bcnt_n    = r_bcnt + 8'd1;
                    w_rdata_n   = w_rsh;
                    w_tx_data_n = w_rsh[DATA_W-1 -: 8];
                end
            end
            S_ACK, S_ERR: if (w_tx_fire) begin
                w_tx_valid_n = 1'b0;
                w_state_n    = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
        if (w_tmo_hit && !w_rx_fire)
            w_state_n = S_ERR;
        // Error byte and counter are set on entry so both appear together
        if (w_state_n == S_ERR && r_state != S_ERR) begin
            w_tx_valid_n = 1'b1;
            w_tx_data_n  = B_ERR;
            if (r_err != 8'hFF)
                w_err_n = r_err + 8'd1;
        end
        w_rx_ready_n = (w_state_n == S_IDLE) || (w_state_n == S_LEN) ||
                       (w_state_n == S_ADDR) || (w_state_n == S_WDATA);
        w_busy_n     = (w_state_n != S_IDLE);
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst) begin
            r_state     <= S_IDLE;
            r_rx_ready  <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= 8'd0;
            r_req_valid <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_busy      <= 1'b0;
            r_err       <= 8'd0;
            r_bcnt      <= 8'd0;
            r_wcnt      <= 8'd0;
        end else begin
            r_state     <= w_state_n;
            r_rx_ready  <= w_rx_ready_n;
            r_tx_valid  <= w_tx_valid_n;
            r_tx_data   <= w_tx_data_n;
            r_req_valid <= w_req_valid_n;
            r_we        <= w_we_n;
            r_addr      <= w_addr_n;
            r_wdata     <= w_wdata_n;
            r_rdata     <= w_rdata_n;
            r_busy      <= w_busy_n;
            r_err       <= w_err_n;
            r_bcnt      <= w_bcnt_n;
            r_wcnt      <= w_wcnt_n;
        end
    end

    assign rx_ready      = r_rx_ready;
    assign tx_valid      = r_tx_valid;
    assign tx_data       = r_tx_data;
    assign mem_req_valid = r_req_valid;
    assign mem_req_we    = r_we;
    assign mem_req_addr  = r_addr;
    assign mem_req_wdata = r_wdata;
    assign busy          = r_busy;
    assign err_count     = r_err;
endmodule

// File: tb/tb_serial_mem_bridge.sv
// tb_serial_mem_bridge: directed vectors and corner sequences for serial_mem_bridge.
module tb_serial_mem_bridge;
    localparam int ADDR_W    = 28;
    localparam int DATA_W    = 32;
    localparam int BURST_MAX = 16;
    localparam int TIMEOUT   = 100;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_rdata;
    logic              busy;
    logic [7:0]        err_count;

    serial_mem_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .BURST_MAX(BURST_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .sys_clk_i(clk), .sys_rst(rst),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int          rdy_mode = 0;
    logic        tx_hold = 1'b0;
    logic [7:0]  txq[$];
    logic [27:0] rq_addr[$];
    logic        rq_we[$];
    logic [31:0] rq_wdata[$];
    logic [31:0] mem [logic [27:0]];
    int          outstanding = 0;
    int          ovf_err = 0;
    int          stab_err = 0;
    int          rsp_cnt = 0;
    logic [27:0] rsp_addr = '0;
    logic        hold_seen = 1'b0;
    logic [27:0] h_addr;
    logic        h_we;
    logic [31:0] h_wdata;

    function automatic logic [31:0] rd_word(input logic [27:0] a);
        if (mem.exists(a))
            return mem[a];
        return {4'hC, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expired(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Memory model and tx sink; values set here are sampled at the next posedge
    always @(negedge clk) begin
        mem_rsp_valid = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = rd_word(rsp_addr);
                outstanding--;
            end
        end
        if (rdy_mode == 1)
            mem_req_ready = 1'b0;
        else
            mem_req_ready = 1'($urandom_range(0, 1));
        if (mem_req_valid && hold_seen &&
            (mem_req_addr != h_addr || mem_req_we != h_we ||
             mem_req_wdata != h_wdata))
            stab_err++;
        if (mem_req_valid && mem_req_ready) begin
            rq_addr.push_back(mem_req_addr);
            rq_we.push_back(mem_req_we);
            rq_wdata.push_back(mem_req_wdata);
            if (mem_req_we) begin
                mem[mem_req_addr] = mem_req_wdata;
            end else begin
                if (outstanding != 0)
                    ovf_err++;
                outstanding++;
                rsp_cnt  = 3;
                rsp_addr = mem_req_addr;
            end
            hold_seen = 1'b0;
        end else if (mem_req_valid) begin
            hold_seen = 1'b1;
            h_addr    = mem_req_addr;
            h_we      = mem_req_we;
            h_wdata   = mem_req_wdata;
        end else begin
            hold_seen = 1'b0;
        end
        tx_ready = !tx_hold;
        if (tx_valid && tx_ready)
            txq.push_back(tx_data);
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000)
            expired("rx_accept");
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [79:0] b);
        for (int i = 0; i < n; i++)
            send_byte(b[8*(n-1-i) +: 8]);
    endtask

    task automatic wait_tx(input int n, input int budget, input string name);
        int k = 0;
        while (txq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (txq.size() < n)
            expired(name);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (busy)
            expired("wait_idle");
    endtask

    task automatic clear_logs();
        txq.delete();
        rq_addr.delete();
        rq_we.delete();
        rq_wdata.delete();
    endtask

    typedef struct {
        int          n;
        logic [79:0] b;
        logic [7:0]  tx;
        logic [7:0]  errc;
    } vec_t;

    vec_t        vt[7];
    logic [7:0]  rd_exp[8];
    logic [7:0]  d0;
    logic        stable;
    int          k;

    initial begin
        vt[0] = '{1,  80'h41,                   8'h3F, 8'd1};
        vt[1] = '{2,  80'h5200,                 8'h3F, 8'd2};
        vt[2] = '{2,  80'h5211,                 8'h3F, 8'd3};
        vt[3] = '{2,  80'h5700,                 8'h3F, 8'd4};
        vt[4] = '{10, 80'h5701000000_20DEADBEEF, 8'h4B, 8'd4};
        vt[5] = '{2,  80'h57FF,                 8'h3F, 8'd5};
        vt[6] = '{1,  80'h77,                   8'h3F, 8'd6};
        rd_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        tx_ready = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_req_addr", mem_req_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_count", err_count, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rx_ready", rx_ready, 1);

        // Two-word write burst
        clear_logs();
        send_frame(6, 80'h570200000010);
        send_frame(4, 80'h11223344);
        chk("wr_valid_after_last_byte", mem_req_valid, 1);
        send_frame(4, 80'hAABBCCDD);
        wait_tx(1, 300, "wr_ack_wait");
        wait_idle(50);
        chk("wr_ack", txq[0], 8'h4B);
        chk("wr_req_count", rq_addr.size(), 2);
        chk("wr0_addr", rq_addr[0], 28'h10);
        chk("wr0_we", rq_we[0], 1);
        chk("wr0_data", rq_wdata[0], 32'h11223344);
        chk("wr1_addr", rq_addr[1], 28'h11);
        chk("wr1_data", rq_wdata[1], 32'hAABBCCDD);

        // Two-word read burst, no trailing ack
        clear_logs();
        send_frame(6, 80'h520200000010);
        wait_tx(8, 600, "rd_wait");
        wait_idle(50);
        for (int i = 0; i < 8; i++)
            chk($sformatf("rd_byte%0d", i), txq[i], rd_exp[i]);
        repeat (10) @(negedge clk);
        chk("rd_no_extra_tx", txq.size(), 8);
        chk("rd_req_count", rq_addr.size(), 2);
        chk("rd1_addr", rq_addr[1], 28'h11);
        chk("rd1_we", rq_we[1], 0);

        // Error and single-word vectors
        for (int i = 0; i < 7; i++) begin
            clear_logs();
            send_frame(vt[i].n, vt[i].b);
            wait_tx(1, 300, $sformatf("vec%0d_wait", i));
            wait_idle(50);
            chk($sformatf("vec%0d_tx", i), txq[0], vt[i].tx);
            chk($sformatf("vec%0d_err", i), err_count, vt[i].errc);
        end
        chk("vec_mem20", rd_word(28'h20), 32'hDEADBEEF);

        // tx backpressure
        clear_logs();
        tx_hold = 1'b1;
        send_frame(6, 80'h520100000010);
        k = 0;
        while (!tx_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!tx_valid)
            expired("stall_wait");
        d0 = tx_data;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!tx_valid || tx_data != d0)
                stable = 1'b0;
        end
        chk("stall_stable", stable, 1);
        chk("stall_first", d0, 8'h11);
        tx_hold = 1'b0;
        wait_tx(4, 100, "stall_drain");
        wait_idle(50);
        chk("stall_b1", txq[1], 8'h22);
        chk("stall_b3", txq[3], 8'h44);

        // Address wrap
        clear_logs();
        send_frame(6, 80'h52020FFFFFFF);
        wait_tx(8, 600, "wrap_wait");
        wait_idle(50);
        chk("wrap_addr0", rq_addr[0], 28'hFFFFFFF);
        chk("wrap_addr1", rq_addr[1], 28'h0);
        chk("wrap_b0", txq[0], 8'hCF);
        chk("wrap_b4", txq[4], 8'hC0);

        // Reset while a write request is stalled
        clear_logs();
        rdy_mode = 1;
        send_frame(10, 80'h5701000000_3001020304);
        repeat (2) @(negedge clk);
        chk("rstw_valid_held", mem_req_valid, 1);
        chk("rstw_addr_held", mem_req_addr, 28'h30);
        chk("rstw_data_held", mem_req_wdata, 32'h01020304);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_valid_drop", mem_req_valid, 0);
        chk("rstw_busy_drop", busy, 0);
        rst = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        chk("rstw_no_write", rq_addr.size(), 0);
        chk("rstw_err_cleared", err_count, 0);
        send_frame(6, 80'h520100000011);
        wait_tx(4, 300, "rstw_read_wait");
        wait_idle(50);
        chk("rstw_rd_b0", txq[0], 8'hAA);
        chk("rstw_rd_b3", txq[3], 8'hDD);

`ifdef SERIAL_BRIDGE_TIMEOUT_EN
        clear_logs();
        send_frame(2, 80'h5701);
        k = 0;
        while (!tx_valid && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_cycles", k, 100);
        wait_tx(1, 50, "tmo_wait");
        wait_idle(50);
        chk("tmo_tx", txq[0], 8'h3F);
        chk("tmo_no_req", rq_addr.size(), 0);
`endif

        chk("one_read_outstanding", ovf_err, 0);
        chk("req_stable", stab_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/serial_mem_bridge.md
# serial_mem_bridge

Byte-stream command engine between the UART byte path and a word-addressed memory request port (the DDR3 user side in the board build). It parses framed read/write commands from received bytes, issues bursts of single-word memory requests with a valid/ready handshake, and returns read data or an acknowledge byte on the transmit stream. It generalises the fixed serial-to-DRAM path with parametrised data and address widths, variable burst length, protocol error reporting and an optional inter-byte timeout.

## Interface
- ADDR_W, 28, word address width; sent as ceil(ADDR_W/8) bytes, MSB first.
- DATA_W, 32, memory word width; multiple of 8; NB = DATA_W/8 bytes per word.
- BURST_MAX, 16, maximum words per command (1..255).
- TIMEOUT, 1000000, inter-byte timeout in cycles (used only with the macro).

- sys_clk_i  in  1  single clock.
- sys_rst  in  1  synchronous, active-high reset.
- rx_valid / rx_data / rx_ready  in / in / out  1 / 8 / 1  received byte stream.
- tx_valid / tx_data / tx_ready  out / out / in  1 / 8 / 1  transmit byte stream.
- mem_req_valid / mem_req_ready  out / in  1 / 1  request handshake.
- mem_req_we  out  1  1 = write.
- mem_req_addr  out  ADDR_W  word address.
- mem_req_wdata  out  DATA_W  write data.
- mem_rsp_valid  in  1  read data valid; one-cycle pulse, no backpressure.
- mem_rsp_rdata  in  DATA_W  read data.
- busy  out  1  high in any state except IDLE.
- err_count  out  8  saturating count of protocol errors.

## Operation
- Frame: opcode, length N, address bytes, then for 'W' N*NB data bytes (MSB first per word).
- Opcodes: 0x57 'W', 0x52 'R'; any other opcode -> ERR.
- N = 0 or N > BURST_MAX -> ERR, after the length byte is consumed.
- States: IDLE, LEN, ADDR, WDATA, WREQ, RREQ, RWAIT, RSEND, ACK, ERR.
- rx_ready = 1 only in IDLE, LEN, ADDR, WDATA; a byte is consumed on rx_valid & rx_ready.
- IDLE -> LEN on a valid opcode; LEN -> ADDR; ADDR -> WDATA ('W') or RREQ ('R') after the last address byte.
- WDATA -> WREQ after NB bytes. WREQ holds the request until mem_req_ready. It then moves to WDATA if words remain, else ACK.
- RREQ holds the request until ready, then goes to RWAIT. RWAIT captures mem_rsp_rdata on mem_rsp_valid, then goes to RSEND. RSEND sends NB bytes MSB first, then goes to RREQ if words remain, else IDLE.
- Exactly one read is outstanding at a time.
- Address increments by 1 per word and wraps modulo 2^ADDR_W.
- ACK sends 0x4B 'K', then goes to IDLE. ERR sends 0x3F '?', increments err_count (saturating at 255), then goes to IDLE.
- No 'K' follows a read.

## Timing
- Reset: every output is 0 and the state is IDLE. Internal address, count and byte registers clear.
- Reset mid-command or mid-handshake abandons the command and drops any valid on the next cycle.
- All outputs are registered.
- mem_req_valid rises the cycle after entering WREQ/RREQ. It stays asserted with addr/we/wdata stable until the cycle it is sampled with ready.
- Write request: valid the cycle after the last data byte of the word is consumed.
- Read data: first tx byte is valid the cycle after mem_rsp_valid.
- tx_valid/tx_data stay stable until tx_ready. The next byte may be presented the cycle after acceptance, so throughput is 1 byte/cycle.
- mem_rsp_valid outside RWAIT is ignored.
- rx bytes arriving while rx_ready = 0 are left pending; they are not dropped by this block.

## Configuration
- SERIAL_BRIDGE_TIMEOUT_EN defined:
  - A counter clears on each consumed byte and runs in LEN, ADDR, WDATA.
  - When it reaches TIMEOUT, the block goes to ERR and sends '?'.
  - Words already written remain written.
- SERIAL_BRIDGE_TIMEOUT_EN undefined: no counter logic; a partial frame waits indefinitely.

## Test plan
- Write 'W',0x02,addr 0x0000010 (4 bytes), data 0x11223344 0xAABBCCDD:
  - Two write requests, at addr 0x10 then 0x11, with that data.
  - tx then sends 0x4B.
- Read 'R',0x02, addr 0x10, memory model with random ready and 3-cycle latency:
  - tx sends 11 22 33 44 AA BB CC DD in order.
  - Never more than one read is outstanding.
- Protocol errors:
  - Opcode 0x41 -> tx 0x3F, err_count 1.
  - 'R', N = 0 -> tx 0x3F, err_count 2.
  - N = BURST_MAX+1 -> tx 0x3F.
- Stall and wrap:
  - tx_ready held low 20 cycles -> tx_data stable throughout.
  - Read at addr 0xFFFFFFF, N = 2 -> second request at addr 0.
- Reset during WREQ with mem_req_ready low:
  - Next cycle mem_req_valid = 0, busy = 0.
  - A following 'R' command completes normally.
- Timeout (macro on, TIMEOUT = 100): send 'W',0x01 then go idle -> tx 0x3F 100 cycles after the last byte, no write request issued.
